// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle between the EX/ID/MDU/memory side and pipe_ctrl.
// Parameter: ADDR_W - width of the redirect target address.
// Modports:
//   master : pipeline side. Drives the hazard/event inputs and receives the
//            PC redirect, hold, flush and status signals.
//   slave  : pipe_ctrl. Receives the events and drives the control outputs.
interface pipe_ctrl_if #(
   parameter int unsigned ADDR_W = 32
);
   // Events from the pipeline into the controller.
   logic              ex_jump_req;
   logic [ADDR_W-1:0] ex_jump_addr;
   logic              ex_is_load;
   logic [4:0]        ex_rd;
   logic [4:0]        id_rs1;
   logic [4:0]        id_rs2;
   logic              id_rs1_rd_en;
   logic              id_rs2_rd_en;
   logic              mdu_start;
   logic              mdu_done;
   logic              bus_wait;

   // Controls from the controller back to the pipeline.
   logic              pc_jump_flag;
   logic [ADDR_W-1:0] pc_jump_addr;
   logic              pc_hold;
   logic              if_id_hold;
   logic              id_ex_hold;
   logic              if_id_flush;
   logic              id_ex_flush;
   logic [1:0]        ctrl_state;
   logic              hold_timeout;

   modport master (
      output ex_jump_req, ex_jump_addr, ex_is_load, ex_rd,
             id_rs1, id_rs2, id_rs1_rd_en, id_rs2_rd_en,
             mdu_start, mdu_done, bus_wait,
      input  pc_jump_flag, pc_jump_addr, pc_hold, if_id_hold, id_ex_hold,
             if_id_flush, id_ex_flush, ctrl_state, hold_timeout
   );

   modport slave (
      input  ex_jump_req, ex_jump_addr, ex_is_load, ex_rd,
             id_rs1, id_rs2, id_rs1_rd_en, id_rs2_rd_en,
             mdu_start, mdu_done, bus_wait,
      output pc_jump_flag, pc_jump_addr, pc_hold, if_id_hold, id_ex_hold,
             if_id_flush, id_ex_flush, ctrl_state, hold_timeout
   );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard / redirect controller for a 5-stage in-order core.
// Produces same-cycle PC redirect, per-register hold and flush controls from
// jump requests, multi-cycle MDU operations, memory bus stalls and load-use
// hazards. Only the state (and, optionally, the wait counter) is registered.
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset; forces every output to 0
//   pif    - pipe_ctrl_if.slave bundle (events in, controls out)
// Parameters:
//   ADDR_W  - redirect target width
//   TIMEOUT - maximum number of WAIT cycles before the watchdog fires
// Build option:
//   HOLD_TIMEOUT_EN - when defined, a WAIT watchdog aborts the MDU stall after
//                     TIMEOUT cycles with a one-cycle hold_timeout pulse;
//                     when undefined, WAIT lasts until mdu_done.
module pipe_ctrl #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned TIMEOUT = 64
) (
   input logic      clk,
   input logic      rst_n,
   pipe_ctrl_if.slave pif
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_JFLUSH = 2'd1;
   localparam logic [1:0] S_WAIT   = 2'd2;

   // Elaboration-time sanity check on the watchdog limit.
   if (TIMEOUT == 0) begin : g_bad_timeout
      $error("pipe_ctrl: TIMEOUT must be at least 1");
   end

   logic [1:0] state_q;
   logic [1:0] state_d;

   logic lu_c;
   logic jump_c;
   logic pc_hold_c;
   logic if_id_hold_c;
   logic id_ex_hold_c;
   logic if_id_flush_c;
   logic id_ex_flush_c;
   logic timeout_c;

`ifdef HOLD_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
`endif

   // Load-use hazard: ID reads the register the in-flight load will write.
   assign lu_c = pif.ex_is_load && (pif.ex_rd != 5'd0) &&
                 ((pif.id_rs1_rd_en && (pif.id_rs1 == pif.ex_rd)) ||
                  (pif.id_rs2_rd_en && (pif.id_rs2 == pif.ex_rd)));

   // Next-state and control decode.
   always_comb begin
      state_d       = state_q;
      jump_c        = 1'b0;
      pc_hold_c     = 1'b0;
      if_id_hold_c  = 1'b0;
      id_ex_hold_c  = 1'b0;
      if_id_flush_c = 1'b0;
      id_ex_flush_c = 1'b0;
      timeout_c     = 1'b0;
`ifdef HOLD_TIMEOUT_EN
      cnt_d         = cnt_q;
`endif
      // Outputs stay quiet for as long as reset is held.
      if (rst_n) begin
         case (state_q)
            S_IDLE: begin
               if (pif.ex_jump_req) begin
                  jump_c        = 1'b1;
                  if_id_flush_c = 1'b1;
                  id_ex_flush_c = 1'b1;
                  state_d       = S_JFLUSH;
               end else if (pif.mdu_start) begin
                  // A result ready in the issue cycle needs no stall.
                  if (!pif.mdu_done) begin
                     pc_hold_c    = 1'b1;
                     if_id_hold_c = 1'b1;
                     id_ex_hold_c = 1'b1;
                     state_d      = S_WAIT;
`ifdef HOLD_TIMEOUT_EN
                     cnt_d        = '0;
`endif
                  end
               end else if (pif.bus_wait) begin
                  pc_hold_c    = 1'b1;
                  if_id_hold_c = 1'b1;
                  id_ex_hold_c = 1'b1;
               end else if (lu_c) begin
                  pc_hold_c     = 1'b1;
                  if_id_hold_c  = 1'b1;
                  id_ex_flush_c = 1'b1;
               end
            end

            S_JFLUSH: begin
               // Drop the wrong-path fetch returned by the synchronous imem.
               if_id_flush_c = 1'b1;
               if (pif.bus_wait) begin
                  pc_hold_c = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end

            S_WAIT: begin
               if (pif.mdu_done) begin
                  state_d = S_IDLE;
`ifdef HOLD_TIMEOUT_EN
               end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                  // This WAIT cycle is the TIMEOUT-th: give up and bubble EX.
                  timeout_c     = 1'b1;
                  id_ex_flush_c = 1'b1;
                  state_d       = S_IDLE;
               end else begin
                  pc_hold_c    = 1'b1;
                  if_id_hold_c = 1'b1;
                  id_ex_hold_c = 1'b1;
                  if (cnt_q != CNT_W'(TIMEOUT)) begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
`else
               end else begin
                  pc_hold_c    = 1'b1;
                  if_id_hold_c = 1'b1;
                  id_ex_hold_c = 1'b1;
`endif
               end
            end

            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

`ifdef HOLD_TIMEOUT_EN
   // WAIT watchdog counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`endif

   // Output drive; a flush always overrides a hold on the same register.
   assign pif.pc_jump_flag = jump_c;
   assign pif.pc_jump_addr = jump_c ? pif.ex_jump_addr : '0;
   assign pif.pc_hold      = pc_hold_c;
   assign pif.if_id_hold   = if_id_hold_c && !if_id_flush_c;
   assign pif.id_ex_hold   = id_ex_hold_c && !id_ex_flush_c;
   assign pif.if_id_flush  = if_id_flush_c;
   assign pif.id_ex_flush  = id_ex_flush_c;
   assign pif.ctrl_state   = state_q;
   assign pif.hold_timeout = timeout_c;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_pipe_ctrl;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned TMO    = 8;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   pipe_ctrl_if #(.ADDR_W(ADDR_W)) pif ();

   pipe_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TMO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .pif   (pif)
   );

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // mode: 0 = running, 1 = one flush cycle owed after a redirect, 2 = MDU stall
   int m_mode = 0;
   int m_wc   = 0;   // WAIT cycles already completed
   int n_mode = 0;
   int n_wc   = 0;

   always @(negedge clk) begin
      logic        lu;
      logic        e_flag, e_pch, e_ifh, e_idh, e_iff, e_idf, e_to;
      logic [31:0] e_addr;
      int          k;
      e_flag = 0; e_pch = 0; e_ifh = 0; e_idh = 0; e_iff = 0; e_idf = 0; e_to = 0;
      e_addr = 0;
      n_mode = m_mode;
      n_wc   = m_wc;
      lu = pif.ex_is_load && pif.ex_rd != 0 &&
           ((pif.id_rs1_rd_en && pif.id_rs1 == pif.ex_rd) ||
            (pif.id_rs2_rd_en && pif.id_rs2 == pif.ex_rd));
      if (!rst_n) begin
         n_mode = 0;
         n_wc   = 0;
      end else if (m_mode == 0) begin
         if (pif.ex_jump_req) begin
            e_flag = 1; e_addr = pif.ex_jump_addr; e_iff = 1; e_idf = 1;
            n_mode = 1;
         end else if (pif.mdu_start) begin
            if (!pif.mdu_done) begin
               {e_pch, e_ifh, e_idh} = 3'b111;
               n_mode = 2;
               n_wc   = 0;
            end
         end else if (pif.bus_wait) begin
            {e_pch, e_ifh, e_idh} = 3'b111;
         end else if (lu) begin
            e_pch = 1; e_ifh = 1; e_idf = 1;
         end
      end else if (m_mode == 1) begin
         e_iff = 1;
         if (pif.bus_wait) e_pch = 1;
         else n_mode = 0;
      end else begin
         k = m_wc + 1;
         if (pif.mdu_done) begin
            n_mode = 0;
`ifdef HOLD_TIMEOUT_EN
         end else if (k >= int'(TMO)) begin
            e_to = 1; e_idf = 1;
            n_mode = 0;
`endif
         end else begin
            {e_pch, e_ifh, e_idh} = 3'b111;
            n_wc = k;
         end
      end
      chk("pc_jump_flag", 64'(pif.pc_jump_flag), 64'(e_flag));
      chk("pc_jump_addr", 64'(pif.pc_jump_addr), 64'(e_addr));
      chk("pc_hold",      64'(pif.pc_hold),      64'(e_pch));
      chk("if_id_hold",   64'(pif.if_id_hold),   64'(e_ifh));
      chk("id_ex_hold",   64'(pif.id_ex_hold),   64'(e_idh));
      chk("if_id_flush",  64'(pif.if_id_flush),  64'(e_iff));
      chk("id_ex_flush",  64'(pif.id_ex_flush),  64'(e_idf));
      chk("hold_timeout", 64'(pif.hold_timeout), 64'(e_to));
      chk("ctrl_state",   64'(pif.ctrl_state),   64'(rst_n ? m_mode : 0));
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode = 0;
         m_wc   = 0;
      end else begin
         m_mode = n_mode;
         m_wc   = n_wc;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle_in();
      pif.ex_jump_req  = 0; pif.ex_jump_addr = '0; pif.ex_is_load = 0;
      pif.ex_rd        = 0; pif.id_rs1 = 0; pif.id_rs2 = 0;
      pif.id_rs1_rd_en = 0; pif.id_rs2_rd_en = 0;
      pif.mdu_start    = 0; pif.mdu_done = 0; pif.bus_wait = 0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset with busy inputs: outputs must stay 0.
      rst_n = 0;
      idle_in();
      pif.ex_jump_req = 1; pif.ex_jump_addr = 32'hDEAD_BEEF; pif.bus_wait = 1;
      @(negedge clk);
      chk("rst_jump_flag", 64'(pif.pc_jump_flag), 64'd0);
      chk("rst_pc_hold",   64'(pif.pc_hold),      64'd0);
      next_cycle();
      rst_n = 1;
      idle_in();
      next_cycle();

      // Jump redirect.
      pif.ex_jump_req = 1; pif.ex_jump_addr = 32'h0000_0100;
      @(negedge clk);
      chk("j0_flag",  64'(pif.pc_jump_flag), 64'd1);
      chk("j0_addr",  64'(pif.pc_jump_addr), 64'h100);
      chk("j0_iff",   64'(pif.if_id_flush),  64'd1);
      chk("j0_idf",   64'(pif.id_ex_flush),  64'd1);
      chk("j0_hold",  64'(pif.pc_hold),      64'd0);
      next_cycle();
      idle_in();
      @(negedge clk);
      chk("j1_state", 64'(pif.ctrl_state),   64'd1);
      chk("j1_iff",   64'(pif.if_id_flush),  64'd1);
      chk("j1_addr",  64'(pif.pc_jump_addr), 64'd0);
      next_cycle();
      @(negedge clk);
      chk("j2_state", 64'(pif.ctrl_state),   64'd0);
      next_cycle();

      // Load-use bubble, then the x0 exemption.
      pif.ex_is_load = 1; pif.ex_rd = 5; pif.id_rs2 = 5; pif.id_rs2_rd_en = 1;
      @(negedge clk);
      chk("lu_pch", 64'(pif.pc_hold),     64'd1);
      chk("lu_ifh", 64'(pif.if_id_hold),  64'd1);
      chk("lu_idf", 64'(pif.id_ex_flush), 64'd1);
      chk("lu_idh", 64'(pif.id_ex_hold),  64'd0);
      next_cycle();
      pif.ex_rd = 0; pif.id_rs2 = 0;
      @(negedge clk);
      chk("lu0_pch", 64'(pif.pc_hold),     64'd0);
      chk("lu0_idf", 64'(pif.id_ex_flush), 64'd0);
      next_cycle();
      idle_in();

      // MDU with done 4 cycles after start.
      pif.mdu_start = 1;
      @(negedge clk);
      chk("mdu_c0_hold", 64'(pif.id_ex_hold), 64'd1);
      next_cycle();
      pif.mdu_start = 0;
      for (int i = 1; i < 4; i++) begin
         @(negedge clk);
         chk("mdu_wait_state", 64'(pif.ctrl_state), 64'd2);
         chk("mdu_wait_hold",  64'(pif.pc_hold),    64'd1);
         next_cycle();
      end
      pif.mdu_done = 1;
      @(negedge clk);
      chk("mdu_done_hold", 64'(pif.pc_hold), 64'd0);
      next_cycle();
      pif.mdu_done = 0;
      @(negedge clk);
      chk("mdu_idle", 64'(pif.ctrl_state), 64'd0);
      next_cycle();
      pif.mdu_start = 1; pif.mdu_done = 1;
      @(negedge clk);
      chk("mdu_same_hold", 64'(pif.pc_hold), 64'd0);
      next_cycle();
      idle_in();
      @(negedge clk);
      chk("mdu_same_state", 64'(pif.ctrl_state), 64'd0);
      next_cycle();

      // Every event at once: jump wins; bus_wait then stretches JFLUSH.
      pif.ex_jump_req = 1; pif.ex_jump_addr = 32'h0000_0ABC; pif.mdu_start = 1;
      pif.bus_wait = 1; pif.ex_is_load = 1; pif.ex_rd = 3; pif.id_rs1 = 3;
      pif.id_rs1_rd_en = 1;
      @(negedge clk);
      chk("all_flag", 64'(pif.pc_jump_flag), 64'd1);
      chk("all_addr", 64'(pif.pc_jump_addr), 64'hABC);
      chk("all_pch",  64'(pif.pc_hold),      64'd0);
      next_cycle();
      idle_in();
      pif.bus_wait = 1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("jf_bw_state", 64'(pif.ctrl_state), 64'd1);
         chk("jf_bw_pch",   64'(pif.pc_hold),    64'd1);
         next_cycle();
      end
      pif.bus_wait = 0;
      @(negedge clk);
      chk("jf_last_state", 64'(pif.ctrl_state), 64'd1);
      chk("jf_last_pch",   64'(pif.pc_hold),    64'd0);
      next_cycle();
      @(negedge clk);
      chk("jf_exit_state", 64'(pif.ctrl_state), 64'd0);
      next_cycle();

      // Watchdog / unbounded WAIT.
      pif.mdu_start = 1;
      next_cycle();
      pif.mdu_start = 0;
`ifdef HOLD_TIMEOUT_EN
      for (int k = 1; k <= int'(TMO); k++) begin
         @(negedge clk);
         chk("to_pulse", 64'(pif.hold_timeout), 64'((k == int'(TMO)) ? 1 : 0));
         chk("to_hold",  64'(pif.pc_hold),      64'((k == int'(TMO)) ? 0 : 1));
         next_cycle();
      end
      @(negedge clk);
      chk("to_exit_state", 64'(pif.ctrl_state), 64'd0);
      next_cycle();
`else
      for (int k = 1; k <= 105; k++) begin
         next_cycle();
      end
      @(negedge clk);
      chk("nowd_state", 64'(pif.ctrl_state),   64'd2);
      chk("nowd_hold",  64'(pif.pc_hold),      64'd1);
      chk("nowd_to",    64'(pif.hold_timeout), 64'd0);
      next_cycle();
      pif.mdu_done = 1;
      next_cycle();
      pif.mdu_done = 0;
`endif

      // Reset in the middle of WAIT.
      pif.mdu_start = 1;
      next_cycle();
      pif.mdu_start = 0;
      next_cycle();
      rst_n = 0;
      #1;
      chk("rstw_pch",   64'(pif.pc_hold),    64'd0);
      chk("rstw_idh",   64'(pif.id_ex_hold), 64'd0);
      chk("rstw_state", 64'(pif.ctrl_state), 64'd0);
      next_cycle();
      rst_n = 1;
      @(negedge clk);
      chk("rstw_after_state", 64'(pif.ctrl_state), 64'd0);
      chk("rstw_after_pch",   64'(pif.pc_hold),    64'd0);
      next_cycle();

      // Randomized traffic; the model process checks every cycle.
      for (int n = 0; n < 3000; n++) begin
         rst_n            = ($urandom_range(0, 63) != 0);
         pif.ex_jump_req  = ($urandom_range(0, 99) < 15);
         pif.ex_jump_addr = $urandom;
         pif.ex_is_load   = ($urandom_range(0, 1) == 1);
         pif.ex_rd        = 5'($urandom_range(0, 3));
         pif.id_rs1       = 5'($urandom_range(0, 3));
         pif.id_rs2       = 5'($urandom_range(0, 3));
         pif.id_rs1_rd_en = ($urandom_range(0, 1) == 1);
         pif.id_rs2_rd_en = ($urandom_range(0, 1) == 1);
         pif.mdu_start    = ($urandom_range(0, 99) < 15);
         pif.mdu_done     = ($urandom_range(0, 99) < 20);
         pif.bus_wait     = ($urandom_range(0, 99) < 20);
         next_cycle();
      end
      rst_n = 1;
      idle_in();
      @(negedge clk);
      #1;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, giving the width of the jump target address.
REQ-002 The block SHALL have parameter TIMEOUT, default 64, giving the maximum number of multi-cycle wait cycles; it is used only with HOLD_TIMEOUT_EN.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset, with these ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ex_jump_req  in  1  EX stage requests a branch/jump redirect.
- ex_jump_addr  in  ADDR_W  redirect target.
- ex_is_load  in  1  EX stage holds a load.
- ex_rd  in  5  EX destination register.
- id_rs1, id_rs2  in  5 each  ID source registers.
- id_rs1_rd_en, id_rs2_rd_en  in  1 each  the source register is actually read.
- mdu_start  in  1  EX issues a multi-cycle mul/div operation.
- mdu_done  in  1  multi-cycle result is valid.
- bus_wait  in  1  memory bus is not ready.
- pc_jump_flag  out  1  load the PC with pc_jump_addr.
- pc_jump_addr  out  ADDR_W  PC redirect target.
- pc_hold, if_id_hold, id_ex_hold  out  1 each  freeze the PC / IF-ID / ID-EX registers.
- if_id_flush, id_ex_flush  out  1 each  zero the IF-ID / ID-EX registers (bubble).
- ctrl_state  out  2  current state: IDLE=0, JFLUSH=1, WAIT=2.
- hold_timeout  out  1  wait watchdog fired (single-cycle pulse).

Function
REQ-004 The block SHALL compute the load-use hazard as LU = ex_is_load & (ex_rd!=0) & ((id_rs1_rd_en & id_rs1==ex_rd) | (id_rs2_rd_en & id_rs2==ex_rd)).
REQ-005 All outputs SHALL be combinational from the current state and inputs in the same cycle, with zero latency; only the state and the wait counter SHALL be registered.
REQ-006 Per-cycle priority in IDLE SHALL be: ex_jump_req > mdu_start > bus_wait > LU > none.
REQ-007 On IDLE with ex_jump_req: pc_jump_flag=1, pc_jump_addr=ex_jump_addr, if_id_flush=1 and id_ex_flush=1, with no holds; next state is JFLUSH.
REQ-008 In JFLUSH, if_id_flush=1 to discard the wrong-path fetch returned by the synchronous instruction memory.
- ex_jump_req and mdu_start are ignored, because EX holds a bubble.
- If bus_wait=1, pc_hold=1 and the state stays JFLUSH; otherwise the next state is IDLE.
REQ-009 On IDLE with mdu_start and mdu_done both low, pc_hold, if_id_hold and id_ex_hold SHALL be 1 and the next state SHALL be WAIT.
REQ-010 On IDLE with mdu_start and mdu_done both high, the block SHALL assert no holds and SHALL stay in IDLE.
REQ-011 In WAIT, all three holds SHALL be 1 while mdu_done=0; in the cycle with mdu_done=1, all holds are 0 and the next state is IDLE.
REQ-012 On IDLE with bus_wait only, all three holds SHALL be 1 and the state SHALL stay IDLE.
REQ-013 On IDLE with LU only, the block SHALL assert pc_hold=1, if_id_hold=1 and id_ex_flush=1 for one cycle (bubble insert), with no state change.
REQ-014 The hold and flush for the same register SHALL never be asserted in the same cycle; flush wins.
REQ-015 pc_jump_addr SHALL be 0 whenever pc_jump_flag=0.
REQ-016 The wait counter SHALL clear on entry to WAIT, increment each WAIT cycle, and saturate at TIMEOUT.

Reset
REQ-017 While rst_n=0, the state SHALL be IDLE, the counter SHALL be 0, and every output SHALL be 0, regardless of the inputs.
REQ-018 An assertion of rst_n in JFLUSH or WAIT SHALL abort the sequence immediately, with no pending flush or hold after release.

Configuration
REQ-019 When macro HOLD_TIMEOUT_EN is defined, and the counter reaches TIMEOUT in WAIT without mdu_done:
- hold_timeout=1 and id_ex_flush=1 for that one cycle;
- holds are 0;
- the next state is IDLE.
REQ-020 When HOLD_TIMEOUT_EN is undefined, the counter SHALL be absent, hold_timeout SHALL be tied to 0, and WAIT SHALL last until mdu_done.

Verification
REQ-021 Jump: IDLE, ex_jump_req=1, addr=0x0000_0100 -> cycle 0: pc_jump_flag=1, addr=0x100, both flushes; cycle 1: ctrl_state=1, if_id_flush=1; cycle 2: IDLE.
REQ-022 Load-use: ex_is_load=1, ex_rd=5, id_rs2=5, id_rs2_rd_en=1 -> pc_hold=1, if_id_hold=1, id_ex_flush=1, id_ex_hold=0; with ex_rd=0 -> all 0.
REQ-023 MDU: mdu_start, then mdu_done 4 cycles later -> holds high for 4 cycles, low in the done cycle, then IDLE; mdu_start and mdu_done in the same cycle -> no holds.
REQ-024 Simultaneous events: ex_jump_req, mdu_start, bus_wait and LU all 1 in IDLE -> jump behaviour only, next state JFLUSH; bus_wait=1 in JFLUSH for 2 cycles -> JFLUSH held 2 extra cycles with pc_hold=1.
REQ-025 Timeout (HOLD_TIMEOUT_EN, TIMEOUT=8): mdu_start, with mdu_done never asserted -> hold_timeout pulses in the 8th WAIT cycle, then IDLE; without the macro -> WAIT persists past 100 cycles.
REQ-026 Reset mid-WAIT: rst_n=0 during WAIT -> all outputs 0 immediately, ctrl_state=0 after release.
